// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes and
// the datapath mux/ALU select codes also used by alu_control and the datapath.
package multicycle_control_pkg;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEMADR   = 4'd3,
      S_MEMREAD  = 4'd4,
      S_MEMWB    = 4'd5,
      S_MEMWRITE = 4'd6,
      S_EXEC_R   = 4'd7,
      S_EXEC_I   = 4'd8,
      S_ALUWB    = 4'd9,
      S_BRANCH   = 4'd10,
      S_JALR     = 4'd11,
      S_JAL      = 4'd12,
      S_UPPER    = 4'd13
   } state_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [1:0] {
      ALU_ADD    = 2'b00,
      ALU_BRANCH = 2'b01,
      ALU_RTYPE  = 2'b10,
      ALU_ITYPE  = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      SRC_A_PC    = 2'b00,
      SRC_A_OLDPC = 2'b01,
      SRC_A_RS1   = 2'b10,
      SRC_A_ZERO  = 2'b11
   } src_a_e;

   typedef enum logic [1:0] {
      SRC_B_RS2  = 2'b00,
      SRC_B_IMM  = 2'b01,
      SRC_B_FOUR = 2'b10
   } src_b_e;

   typedef enum logic [1:0] {
      RES_ALUOUT  = 2'b00,
      RES_MEMDATA = 2'b01,
      RES_ALURES  = 2'b10
   } result_e;

   function automatic logic is_wait_state(input state_e s);
      return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
   endfunction

   // S_FETCH doubles as the "illegal opcode" result of decode.
   function automatic state_e decode_next(input logic [6:0] op, input logic upper_en);
      case (op)
         OP_LOAD, OP_STORE: return S_MEMADR;
         OP_RTYPE:          return S_EXEC_R;
         OP_ITYPE:          return S_EXEC_I;
         OP_BRANCH:         return S_BRANCH;
         OP_JAL:            return S_JAL;
         OP_JALR:           return S_JALR;
         OP_LUI, OP_AUIPC:  return upper_en ? S_UPPER : S_FETCH;
         default:           return S_FETCH;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: opcode/ready in, enables, selects and status out.
interface multicycle_control_if;
   import multicycle_control_pkg::*;

   logic [6:0] opcode;
   logic       mem_ready;
   logic       pc_write;
   logic       ir_write;
   logic       mem_read;
   logic       mem_write;
   logic       reg_write;
   logic       branch;
   logic       adr_src;
   src_a_e     alu_src_a;
   src_b_e     alu_src_b;
   alu_op_e    alu_op;
   result_e    result_src;
   logic       instr_done;
   logic       illegal;
   logic       mem_fault;

   modport master (
      input  opcode, mem_ready,
      output pc_write, ir_write, mem_read, mem_write, reg_write, branch,
             adr_src, alu_src_a, alu_src_b, alu_op, result_src,
             instr_done, illegal, mem_fault
   );

   modport slave (
      output opcode, mem_ready,
      input  pc_write, ir_write, mem_read, mem_write, reg_write, branch,
             adr_src, alu_src_a, alu_src_b, alu_op, result_src,
             instr_done, illegal, mem_fault
   );

endinterface

// File: rtl/multicycle_control_mem_wait_timer.sv
// Memory wait counter: counts not-ready cycles in a memory state and flags
// expiry when MAX_WAIT (>0) cycles have elapsed without ready.
module mem_wait_timer #(
   parameter int MAX_WAIT = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic ready,
   output logic expire
);

   localparam int              W     = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [W-1:0]    LIMIT = W'(MAX_WAIT);

   logic [W-1:0] cnt_q, cnt_d;

   // Leaving a wait state always coincides with ready or expiry, so clearing
   // on those plus !active covers every state change the controller makes.
   always_comb begin
      expire = (MAX_WAIT > 0) && active && !ready && (cnt_q == LIMIT);
      cnt_d  = cnt_q;
      if (!active || ready || expire) begin
         cnt_d = '0;
      end else if (cnt_q != LIMIT) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V main controller: Moore FSM sequencing fetch, decode,
// execute, memory and write-back, with an optional memory-wait timeout.
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int ENABLE_UPPER = 1,
   parameter int MAX_WAIT     = 0
) (
   input logic                  clk,
   input logic                  rst,
   multicycle_control_if.master bus
);

   state_e state_q, state_d;
   state_e dec_next;
   logic   wait_active;
   logic   expire;

   assign wait_active = is_wait_state(state_q);
   assign dec_next    = decode_next(bus.opcode, ENABLE_UPPER != 0);

   mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
      .clk    (clk),
      .rst    (rst),
      .active (wait_active),
      .ready  (bus.mem_ready),
      .expire (expire)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     state_d = S_FETCH;
         S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
                     else if (expire)   state_d = S_FETCH;
         S_DECODE:   state_d = dec_next;
         S_MEMADR:   state_d = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
                     else if (expire)   state_d = S_FETCH;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: if (bus.mem_ready || expire) state_d = S_FETCH;
         S_EXEC_R:   state_d = S_ALUWB;
         S_EXEC_I:   state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BRANCH:   state_d = S_FETCH;
         S_JALR:     state_d = S_JAL;
         S_JAL:      state_d = S_ALUWB;
         S_UPPER:    state_d = S_ALUWB;
         default:    state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      bus.pc_write   = 1'b0;
      bus.ir_write   = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.reg_write  = 1'b0;
      bus.branch     = 1'b0;
      bus.adr_src    = 1'b0;
      bus.alu_src_a  = SRC_A_PC;
      bus.alu_src_b  = SRC_B_RS2;
      bus.alu_op     = ALU_ADD;
      bus.result_src = RES_ALUOUT;
      bus.instr_done = 1'b0;
      bus.illegal    = 1'b0;
      bus.mem_fault  = expire;
      case (state_q)
         S_FETCH: begin
            bus.mem_read   = 1'b1;
            bus.ir_write   = bus.mem_ready;
            bus.pc_write   = bus.mem_ready;
            bus.alu_src_b  = SRC_B_FOUR;
            bus.result_src = RES_ALURES;
         end
         S_DECODE: begin
            bus.alu_src_a = SRC_A_OLDPC;
            bus.alu_src_b = SRC_B_IMM;
            bus.illegal   = (dec_next == S_FETCH);
         end
         S_MEMADR: begin
            bus.alu_src_a = SRC_A_RS1;
            bus.alu_src_b = SRC_B_IMM;
         end
         S_MEMREAD: begin
            bus.mem_read = 1'b1;
            bus.adr_src  = 1'b1;
         end
         S_MEMWB: begin
            bus.result_src = RES_MEMDATA;
            bus.reg_write  = 1'b1;
            bus.instr_done = 1'b1;
         end
         S_MEMWRITE: begin
            bus.mem_write  = 1'b1;
            bus.adr_src    = 1'b1;
            bus.instr_done = bus.mem_ready;
         end
         S_EXEC_R: begin
            bus.alu_src_a = SRC_A_RS1;
            bus.alu_op    = ALU_RTYPE;
         end
         S_EXEC_I: begin
            bus.alu_src_a = SRC_A_RS1;
            bus.alu_src_b = SRC_B_IMM;
            bus.alu_op    = ALU_ITYPE;
         end
         S_ALUWB: begin
            bus.reg_write  = 1'b1;
            bus.instr_done = 1'b1;
         end
         S_BRANCH: begin
            bus.alu_src_a  = SRC_A_RS1;
            bus.alu_op     = ALU_BRANCH;
            bus.branch     = 1'b1;
            bus.instr_done = 1'b1;
         end
         S_JALR: begin
            bus.alu_src_a = SRC_A_RS1;
            bus.alu_src_b = SRC_B_IMM;
         end
         S_JAL: begin
            bus.pc_write  = 1'b1;
            bus.alu_src_a = SRC_A_OLDPC;
            bus.alu_src_b = SRC_B_FOUR;
         end
         S_UPPER: begin
            bus.alu_src_a = bus.opcode[5] ? SRC_A_ZERO : SRC_A_OLDPC;
            bus.alu_src_b = SRC_B_IMM;
         end
         default: ;
      endcase
   end

endmodule
